// File: rtl/hy_frame_loader.sv
// hy_frame_loader: ping-pong H/Y frame assembler feeding the QR stage.
// Define HYLOAD_SOF_CHECK_EN to enable in_sof framing checks and err_sof.
`ifndef WL
`define WL 16
`endif

module hy_frame_loader #(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sof,
  input  logic [`WL*N-1:0]       in_hrow,
  input  logic [`WL-1:0]         in_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [`WL*N*N-1:0]     Hmatrix_o,
  output logic [`WL*N-1:0]       Yarray_o,
  output logic                   err_sof
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [`WL*N-1:0] h_q [2][N];
  logic [`WL*N-1:0] h_d [2][N];
  logic [`WL-1:0]   y_q [2][N];
  logic [`WL-1:0]   y_d [2][N];
  logic             wbank_q, wbank_d;
  logic             rbank_q, rbank_d;
  logic [1:0]       full_q, full_d;
  logic [CW-1:0]    wcnt_q, wcnt_d;
  logic             err_q, err_d;

  logic             accept;
  logic             wr_en;
  logic [CW-1:0]    wr_row;

  assign in_ready  = ~full_q[wbank_q];
  assign out_valid = full_q[rbank_q];
  assign err_sof   = err_q;

`ifndef HYLOAD_SOF_CHECK_EN
  logic unused_sof;
  assign unused_sof = in_sof;
`endif

  // Row write into the fill bank, frame completion and frame release.
  always_comb begin
    h_d     = h_q;
    y_d     = y_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    full_d  = full_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    accept  = in_valid && in_ready;
    wr_en   = accept;
    wr_row  = wcnt_q;
`ifdef HYLOAD_SOF_CHECK_EN
    if (accept && in_sof && (wcnt_q != '0)) begin
      wr_row = '0;
      err_d  = 1'b1;
    end else if (accept && !in_sof && (wcnt_q == '0)) begin
      wr_en = 1'b0;
      err_d = 1'b1;
    end
`endif
    if (out_valid && out_ready) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
    end
    if (wr_en) begin
      h_d[wbank_q][wr_row] = in_hrow;
      y_d[wbank_q][wr_row] = in_y;
      if (wr_row == LAST) begin
        wcnt_d          = '0;
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end else begin
        wcnt_d = wr_row + 1'b1;
      end
    end
  end

  // State registers; reset discards every frame and clears the banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < N; r++) begin
          h_q[b][r] <= '0;
          y_q[b][r] <= '0;
        end
      end
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      full_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      h_q     <= h_d;
      y_q     <= y_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      full_q  <= full_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  // Present the read bank directly from the registers.
  always_comb begin
    Hmatrix_o = '0;
    Yarray_o  = '0;
    for (int i = 0; i < N; i++) begin
      Hmatrix_o[i*`WL*N +: `WL*N] = h_q[rbank_q][i];
      Yarray_o[i*`WL +: `WL]      = y_q[rbank_q][i];
    end
  end

endmodule

// File: doc/hy_frame_loader.md
Name: hy_frame_loader

Overview:
- Upstream feeder for the Givens-rotation QR stage in the 4x4 MIMO detector.
- Accepts the real-valued channel matrix H (N x N) and the receive vector Y one row per beat over a valid/ready stream.
- Assembles each frame into ping-pong register banks and presents a complete packed Hmatrix/Yarray frame with a valid/ready handshake.
- The next frame can load while the current frame is held for the QR pipeline.

Parameters:
- N, 8, matrix dimension (real-valued form of 4x4 complex); row count per frame.
- Element width is the global `WL from parameters.v; it is not a parameter of this block.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a row beat is offered.
- in_ready  output  1  block can accept a row this cycle.
- in_sof  input  1  beat is row 0 of a new frame.
- in_hrow  input  `WL*N  one H row, signed; column j at bits [(j+1)*`WL-1 : j*`WL].
- in_y  input  `WL  Y element for this row, signed.
- out_valid  output  1  complete frame presented.
- out_ready  input  1  consumer takes frame (tie high for a free-running QR pipeline).
- Hmatrix_o  output  `WL*N*N  signed; row i at bits [(i+1)*`WL*N-1 : i*`WL*N].
- Yarray_o  output  `WL*N  signed; element i at bits [(i+1)*`WL-1 : i*`WL].
- err_sof  output  1  sticky framing-error flag (see Optional Feature).

Behaviour:
- State: two banks (bank0, bank1) of N rows plus N y elements; wbank ptr; rbank ptr; full[1:0]; row counter wcnt of width $clog2(N), range 0..N-1.
- Reset (async, rst=1): all bank contents 0; wbank=rbank=0; full=0; wcnt=0; err_sof=0.
  - Resulting outputs: out_valid=0, Hmatrix_o=0, Yarray_o=0, in_ready=1 (combinational from state) from the first cycle after reset deassertion.
- in_ready = ~full[wbank].
- Input accept: the beat is accepted when in_valid && in_ready. It writes in_hrow/in_y into row wcnt of bank wbank, then wcnt increments.
- Frame completion: when the accepted row has wcnt==N-1, wcnt wraps to 0, full[wbank] sets and wbank toggles.
- out_valid = full[rbank]; Hmatrix_o/Yarray_o = bank[rbank], muxed from registers with no extra pipeline register.
- Latency: last row accepted at edge t gives out_valid=1 after edge t. The frame stays stable until consumed.
- Output release: on out_valid && out_ready at an edge, full[rbank] clears and rbank toggles.
- Simultaneous fill-complete and release on the same edge: both take effect. They always target different banks, or the same bank only if that bank was empty.
- Both banks full: in_ready=0; input stalls with no data loss. Upstream must hold the beat per valid/ready rules.
- Throughput: with out_ready=1, one frame every N cycles, no bubbles.
- in_valid low mid-frame: wcnt holds; partial frame is retained indefinitely.
- Reset mid-frame or mid-hold: all partial and full frames are discarded immediately.
- Bank contents never clear except on reset. A frame's old data remains visible but out_valid=0 once released.

Optional Feature:
- Macro: HYLOAD_SOF_CHECK_EN.
- Defined:
  - An accepted beat with in_sof=1 while wcnt!=0 drops the partial frame. The beat is written as row 0, wcnt becomes 1 and err_sof sets.
  - An accepted beat with in_sof=0 while wcnt==0 is dropped (not written, wcnt stays 0) and err_sof sets.
  - err_sof is sticky until rst.
- Undefined: in_sof is ignored, every accepted beat is written at wcnt, and err_sof is tied to 0.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, Hmatrix_o=0, Yarray_o=0, err_sof=0.
- One frame, N=8, out_ready=1: row i has element j = i*8+j and y = 100+i -> out_valid goes high one cycle after the 8th beat; Hmatrix_o row 3 column 5 = 29; Yarray_o element 7 = 107; frame released the next edge.
- out_ready=0, three frames offered back-to-back -> frames 1 and 2 fill both banks, in_ready=0 while frame 3 row 0 is held. Raise out_ready -> frame 1 (rbank=0), then frame 2, then frame 3, each intact in order.
- Continuous stream with out_ready=1 -> out_valid every 8 cycles, in_ready never drops.
- Assert rst after 5 rows of a frame and with one full bank -> out_valid=0, wcnt=0, all outputs 0. The next 8 rows form a clean frame.
- With HYLOAD_SOF_CHECK_EN: send in_sof at row 4 -> err_sof=1, and the frame completes 7 beats later using the new rows only. Without the macro, the same stimulus gives a frame after row 7 with err_sof=0.
